// File: rtl/snn_pkg.sv
// ============================================================================
// Module  : snn_pkg
// Brief   : Shared geometry defaults and FSM state type for the SNN conv
//           scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package snn_pkg;

  localparam int DEPTH_F    = 5;
  localparam int DEPTH_I    = 25;
  localparam int DEPTH_R    = 21;
  localparam int WIDTH_addr = 12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/snn_win_counter.sv
// ============================================================================
// Module  : snn_win_counter
// Brief   : Four-level nested window counter (fc inner, fr, ocol, orow outer).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module snn_win_counter #(
  parameter int DEPTH_F = snn_pkg::DEPTH_F,
  parameter int DEPTH_R = snn_pkg::DEPTH_R,
  parameter int W       = snn_pkg::WIDTH_addr
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_advance,
  output logic [W-1:0] o_fc,
  output logic [W-1:0] o_fr,
  output logic [W-1:0] o_ocol,
  output logic [W-1:0] o_orow,
  output logic         o_tap_last,
  output logic         o_win_last
);

  localparam logic [W-1:0] c_F_MAX = W'(DEPTH_F - 1);
  localparam logic [W-1:0] c_R_MAX = W'(DEPTH_R - 1);
  localparam logic [W-1:0] c_ONE   = W'(1);

  logic [W-1:0] r_fc, r_fr, r_ocol, r_orow;
  logic         w_fc_wrap, w_fr_wrap, w_oc_wrap, w_or_wrap;

  assign w_fc_wrap  = (r_fc == c_F_MAX);
  assign w_fr_wrap  = (r_fr == c_F_MAX);
  assign w_oc_wrap  = (r_ocol == c_R_MAX);
  assign w_or_wrap  = (r_orow == c_R_MAX);
  assign o_tap_last = w_fc_wrap && w_fr_wrap;
  assign o_win_last = o_tap_last && w_oc_wrap && w_or_wrap;

  // Each level steps only when every inner level wraps in the same beat.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_fc   <= '0;
      r_fr   <= '0;
      r_ocol <= '0;
      r_orow <= '0;
    end else if (i_advance) begin
      r_fc <= w_fc_wrap ? '0 : r_fc + c_ONE;
      if (w_fc_wrap)
        r_fr <= w_fr_wrap ? '0 : r_fr + c_ONE;
      if (o_tap_last)
        r_ocol <= w_oc_wrap ? '0 : r_ocol + c_ONE;
      if (o_tap_last && w_oc_wrap)
        r_orow <= w_or_wrap ? '0 : r_orow + c_ONE;
    end
  end

  assign o_fc   = r_fc;
  assign o_fr   = r_fr;
  assign o_ocol = r_ocol;
  assign o_orow = r_orow;

endmodule

`default_nettype wire

// File: rtl/snn_conv_scheduler.sv
// ============================================================================
// Module  : snn_conv_scheduler
// Brief   : Two-timestep convolution MAC request scheduler with result drain.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module snn_conv_scheduler #(
  parameter int DEPTH_F    = snn_pkg::DEPTH_F,
  parameter int DEPTH_I    = snn_pkg::DEPTH_I,
  parameter int DEPTH_R    = snn_pkg::DEPTH_R,
  parameter int WIDTH_addr = snn_pkg::WIDTH_addr
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_done,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [WIDTH_addr-1:0] ifmap_addr,
  output logic [WIDTH_addr-1:0] filter_addr,
  output logic [WIDTH_addr-1:0] out_addr,
  output logic [1:0]            ts,
  output logic                  mac_first,
  output logic                  mac_last,
  input  logic                  res_valid,
  output logic                  start_r,
  output logic                  ts_done,
  output logic                  done_r,
  output logic                  busy
);

  import snn_pkg::*;

  localparam logic [WIDTH_addr-1:0] c_F     = WIDTH_addr'(DEPTH_F);
  localparam logic [WIDTH_addr-1:0] c_I     = WIDTH_addr'(DEPTH_I);
  localparam logic [WIDTH_addr-1:0] c_R     = WIDTH_addr'(DEPTH_R);
  localparam logic [WIDTH_addr-1:0] c_N_OUT = WIDTH_addr'(DEPTH_R * DEPTH_R);

  state_t                r_state, w_next;
  logic [1:0]            r_ts;
  logic [WIDTH_addr-1:0] r_res_cnt;
  logic [WIDTH_addr-1:0] w_fc, w_fr, w_ocol, w_orow;
  logic                  w_tap_last, w_win_last;
  logic                  w_adv, w_load_go, w_cnt_full, w_ts_end;

  assign w_load_go  = (r_state == S_LOAD) && load_done;
  assign w_cnt_full = (r_res_cnt == c_N_OUT);
  assign w_ts_end   = (r_state == S_DRAIN) && w_cnt_full;
  assign w_adv      = req_valid && req_ready;

  snn_win_counter #(
    .DEPTH_F (DEPTH_F),
    .DEPTH_R (DEPTH_R),
    .W       (WIDTH_addr)
  ) u_win (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_load_go || w_ts_end),
    .i_advance  (w_adv),
    .o_fc       (w_fc),
    .o_fr       (w_fr),
    .o_ocol     (w_ocol),
    .o_orow     (w_orow),
    .o_tap_last (w_tap_last),
    .o_win_last (w_win_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ts      <= 2'd1;
      r_res_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_go) begin
        r_ts      <= 2'd1;
        r_res_cnt <= '0;
      end else if (w_ts_end) begin
        r_res_cnt <= '0;
        if (r_ts == 2'd1)
          r_ts <= 2'd2;
      end else if (res_valid && (r_state == S_ISSUE || r_state == S_DRAIN)) begin
        r_res_cnt <= r_res_cnt + WIDTH_addr'(1);
      end
    end
  end

  // Pulses are masked while rst is high so nothing leaks out of a reset cycle.
  always_comb begin
    w_next    = r_state;
    req_valid = 1'b0;
    start_r   = 1'b0;
    ts_done   = 1'b0;
    done_r    = 1'b0;
    case (r_state)
      S_IDLE:  if (load_start) w_next = S_LOAD;
      S_LOAD: begin
        if (load_done) begin
          w_next  = S_ISSUE;
          start_r = !rst;
        end
      end
      S_ISSUE: begin
        req_valid = 1'b1;
        if (req_ready && w_win_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_cnt_full) begin
          ts_done = !rst;
          w_next  = (r_ts == 2'd1) ? S_ISSUE : S_DONE;
        end
      end
      S_DONE: begin
        done_r = !rst;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign ts          = r_ts;
  assign filter_addr = req_valid ? (w_fr * c_F + w_fc) : '0;
  assign ifmap_addr  = req_valid ? ((w_orow + w_fr) * c_I + (w_ocol + w_fc)) : '0;
  assign out_addr    = req_valid ? (w_orow * c_R + w_ocol) : '0;
  assign mac_first   = req_valid && (w_fr == '0) && (w_fc == '0);
  assign mac_last    = req_valid && w_tap_last;

endmodule

`default_nettype wire

// File: tb/tb_snn_conv_scheduler.sv
// ============================================================================
// Module  : tb_snn_conv_scheduler
// Brief   : Scoreboard bench for snn_conv_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snn_conv_scheduler;

  localparam int F  = 5;
  localparam int I  = 25;
  localparam int R  = 21;
  localparam int NB = F * F * R * R;

  typedef struct packed {
    logic [11:0] ifm;
    logic [11:0] fil;
    logic [11:0] oa;
    logic [1:0]  ts;
    logic        first;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        load_done = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [11:0] ifmap_addr, filter_addr, out_addr;
  logic [1:0]  ts;
  logic        mac_first, mac_last;
  logic        res_valid = 1'b0;
  logic        start_r, ts_done, done_r, busy;

  logic        man_res = 1'b0;
  logic        hold = 1'b0;

  always #5 clk = ~clk;

  snn_conv_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .load_done   (load_done),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .ifmap_addr  (ifmap_addr),
    .filter_addr (filter_addr),
    .out_addr    (out_addr),
    .ts          (ts),
    .mac_first   (mac_first),
    .mac_last    (mac_last),
    .res_valid   (res_valid),
    .start_r     (start_r),
    .ts_done     (ts_done),
    .done_r      (done_r),
    .busy        (busy)
  );

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    beat_idx, beats_ts1, beats_ts2, n_start, n_tsdone, n_done;
  int    res_seen, res_at_ts2;
  logic  got_ts2;
  beat_t b1, b26, b526, blast, bts2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ts(input int t);
    beat_t b;
    for (int orow = 0; orow < R; orow++)
      for (int ocol = 0; ocol < R; ocol++)
        for (int fr = 0; fr < F; fr++)
          for (int fc = 0; fc < F; fc++) begin
            b.ifm   = 12'((orow + fr) * I + ocol + fc);
            b.fil   = 12'(fr * F + fc);
            b.oa    = 12'(orow * R + ocol);
            b.ts    = 2'(t);
            b.first = (fr == 0 && fc == 0);
            b.last  = (fr == F - 1 && fc == F - 1);
            exp_q.push_back(b);
          end
  endtask

  // Monitor plus datapath model: sample first, then update res_valid.
  logic [2:0] pipe = 3'b0;
  int         pend = 0;
  beat_t      hold_b;
  logic       armed = 1'b0;
  always @(negedge clk) begin : monitor
    beat_t cb, e;
    logic  xl;
    cb = {ifmap_addr, filter_addr, out_addr, ts, mac_first, mac_last};
    xl = 1'b0;
    if (start_r)  n_start++;
    if (ts_done)  n_tsdone++;
    if (done_r)   n_done++;
    if (!rst) begin
      if (res_valid) res_seen++;
      if (armed) begin
        n_tests++;
        if (!(req_valid && cb == hold_b)) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%0d fields=%h, expected valid=1 fields=%h",
                   req_valid, cb, hold_b);
        end
      end
      armed  = req_valid && !req_ready;
      hold_b = cb;
      if (req_valid && req_ready) begin
        xl = mac_last;
        beat_idx++;
        if (cb.ts == 2'd1) begin
          beats_ts1++;
          if (beats_ts1 == 1)   b1    = cb;
          if (beats_ts1 == 26)  b26   = cb;
          if (beats_ts1 == 526) b526  = cb;
          if (beats_ts1 == NB)  blast = cb;
        end else begin
          beats_ts2++;
          if (beats_ts2 == 1) begin
            bts2       = cb;
            got_ts2    = 1'b1;
            res_at_ts2 = res_seen;
          end
        end
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL beat_unexpected: got %h, expected no beat", cb);
        end else begin
          e = exp_q.pop_front();
          if (cb !== e) begin
            n_fail++;
            $display("FAIL beat_%0d: got ifm=%0d fil=%0d out=%0d ts=%0d f=%0d l=%0d, expected ifm=%0d fil=%0d out=%0d ts=%0d f=%0d l=%0d",
                     beat_idx, cb.ifm, cb.fil, cb.oa, cb.ts, cb.first, cb.last,
                     e.ifm, e.fil, e.oa, e.ts, e.first, e.last);
          end
        end
      end
      if (pipe[2]) pend++;
      pipe = {pipe[1:0], xl};
    end else begin
      armed = 1'b0;
      pipe  = 3'b0;
      pend  = 0;
    end
    res_valid = man_res || (!hold && pend > 0 && !rst);
    if (!hold && pend > 0 && !rst) pend--;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    beat_idx = 0; beats_ts1 = 0; beats_ts2 = 0;
    n_start = 0; n_tsdone = 0; n_done = 0;
    res_seen = 0; res_at_ts2 = 0; got_ts2 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tick();
    tick();
    load_done = 1'b1;
    @(negedge clk);
    chk("start_r_pulse", start_r, 1);
    @(posedge clk);
    #1;
    load_done = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    @(negedge clk);
    chk({name, "_ctrl"}, {req_valid, busy, mac_first, mac_last, start_r, ts_done, done_r}, 0);
    chk({name, "_addr"}, {ifmap_addr, filter_addr, out_addr}, 0);
    chk({name, "_ts"}, ts, 1);
  endtask

  initial begin : main
    int c, bad;
    clear_stats();
    do_reset();
    check_idle_outputs("reset");

    // Stray load_done and res_valid while idle
    tick();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    man_res = 1'b1;
    tick();
    man_res = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_pulses", n_start + n_tsdone + n_done, 0);
    tick();

    // Full two-timestep run with ready held high
    clear_stats();
    push_ts(1);
    push_ts(2);
    req_ready = 1'b1;
    load();
    c = 0;
    while (n_done == 0 && c < 25000) begin tick(); c++; end
    chk("full_done_r", n_done, 1);
    chk("full_beats_ts1", beats_ts1, NB);
    chk("full_beats_ts2", beats_ts2, NB);
    chk("full_ts_done", n_tsdone, 2);
    chk("full_start_r", n_start, 1);
    chk("full_queue_left", exp_q.size(), 0);
    chk("first_beat", {b1.ifm, b1.fil, b1.oa, b1.first}, {12'd0, 12'd0, 12'd0, 1'b1});
    chk("beat26", {b26.oa, b26.ifm, b26.first}, {12'd1, 12'd1, 1'b1});
    chk("beat526", {b526.oa, b526.ifm}, {12'd21, 12'd25});
    chk("last_beat", {blast.ifm, blast.fil, blast.oa, blast.last}, {12'd624, 12'd24, 12'd440, 1'b1});
    chk("ts2_first", {bts2.ifm, bts2.ts}, {12'd0, 2'd2});
    chk("ts2_after_results", res_at_ts2 >= 441, 1);
    tick();
    @(negedge clk);
    chk("full_idle_busy", busy, 0);
    tick();

    // Random backpressure over timestep 1
    clear_stats();
    push_ts(1);
    load();
    c = 0;
    while (n_tsdone == 0 && c < 40000) begin
      req_ready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    req_ready = 1'b0;
    chk("rnd_ts_done", n_tsdone, 1);
    chk("rnd_beats_ts1", beats_ts1, NB);
    chk("rnd_last_beat", {blast.ifm, blast.fil, blast.oa}, {12'd624, 12'd24, 12'd440});
    do_reset();

    // Results withheld: timestep 2 must wait for all 441
    clear_stats();
    push_ts(1);
    push_ts(2);
    hold = 1'b1;
    req_ready = 1'b1;
    load();
    c = 0;
    while (beats_ts1 < NB && c < 12000) begin tick(); c++; end
    chk("hold_beats_ts1", beats_ts1, NB);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_valid !== 1'b0 || ts !== 2'd1 || busy !== 1'b1) bad++;
      @(posedge clk);
      #1;
    end
    chk("hold_no_issue", bad, 0);
    chk("hold_no_ts_done", n_tsdone, 0);
    hold = 1'b0;
    c = 0;
    while (!got_ts2 && c < 1000) begin tick(); c++; end
    chk("hold_ts2_seen", got_ts2, 1);
    chk("hold_ts2_first", {bts2.ifm, bts2.ts, bts2.first}, {12'd0, 2'd2, 1'b1});
    chk("hold_res_count", res_at_ts2, 441);
    chk("hold_ts_done", n_tsdone, 1);
    tick();
    tick();
    do_reset();

    // Reset in the middle of timestep 1, then restart
    clear_stats();
    push_ts(1);
    req_ready = 1'b1;
    load();
    c = 0;
    while (beat_idx < 5000 && c < 6000) begin tick(); c++; end
    chk("mid_beats", beat_idx, 5000);
    rst = 1'b1;
    req_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_idle_outputs("mid_reset");
    tick();
    tick();
    @(negedge clk);
    chk("mid_no_pulses", n_tsdone + n_done, 0);
    chk("mid_res_dropped", res_valid, 0);
    tick();
    clear_stats();
    push_ts(1);
    req_ready = 1'b1;
    load();
    for (int k = 0; k < 60; k++) tick();
    chk("restart_first", {b1.ifm, b1.fil, b1.oa, b1.ts}, {12'd0, 12'd0, 12'd0, 2'd1});
    chk("restart_beats", beats_ts1, 60);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
